mealy_1010_seq_det_non_over: RTL and testbench
==============================================

Name: mealy_1010_seq_det_non_over

Overview:
- Single-bit serial sequence detector for the pattern 1010, built as a Mealy FSM in non-overlapping mode.
- Samples one input bit per rising clock edge.
- Raises a combinational match output during the cycle in which the final 0 of the pattern is present.
- After a match, detection restarts from scratch; bits of a completed match are never reused.
- Used as a leaf block in serial-stream monitors.

Parameters:
- None. Pattern (1010) and mode (non-overlapping) are fixed.

Ports:
- Clk  input  1  system clock; all state updates on the rising edge.
- Rst  input  1  asynchronous, active-low reset.
- In   input  1  serial data bit, sampled at the rising edge of Clk.
- OP   output 1  match flag; Mealy output, combinational from current state and In.
- Positional port order is exactly Clk, Rst, In, OP.

Behaviour:
- Two-process structure:
  - Sequential process holds the state register C_State.
  - Combinational process computes N_State and OP.
  - Both C_State and N_State are 2-bit internal signals with exactly these names; benches probe them hierarchically.
- State encoding:
  - S0 = 2'b00: idle, no progress.
  - S1 = 2'b01: seen "1".
  - S2 = 2'b10: seen "10".
  - S3 = 2'b11: seen "101".
- Reset:
  - Rst=0 forces C_State=S0 immediately, independent of Clk.
  - OP is forced to 0 while Rst=0.
  - First state update occurs at the first rising edge with Rst=1.
- Transitions (C_State, In -> N_State, OP):
  - S0, 0 -> S0, 0
  - S0, 1 -> S1, 0
  - S1, 0 -> S2, 0
  - S1, 1 -> S1, 0
  - S2, 0 -> S0, 0
  - S2, 1 -> S3, 0
  - S3, 0 -> S0, 1  (match; non-overlap, so return to idle)
  - S3, 1 -> S1, 0  (trailing 1 starts a new candidate)
- OP timing:
  - OP = (C_State==S3) & In==0 & Rst.
  - Asserts as soon as In falls to 0 while in S3; no clock latency.
  - Stays high until the next rising edge moves the FSM to S0, or until In changes.
  - Mid-cycle changes of In propagate to OP and N_State immediately.
  - Only the value present at the rising edge affects the state.
- N_State defaults to S0 for any unreachable or illegal encoding.
- OP defaults to 0 in every branch; no latches.
- X on In: no requirement beyond the default branches.
- Reset asserted mid-sequence discards all progress.

Decomposition:
- Shared package: four 2-bit state localparams (S0..S3) and the 2-bit state typedef.
- No sub-module; the block is a single module with one sequential and one combinational process.

Test Plan:
- Reset: Rst=0 from t=0 to 15 with In=0 -> C_State=0 and OP=0 throughout. Pulse Rst low mid-stream while in S3 -> C_State returns to 0 immediately and OP=0.
- Basic match, with Clk period 10 and rising edges at 5, 15, 25 …: sample In = 0,1,0,0,1,0,1 at edges 25–85, then drive In=0 at t=87.
  - Required: C_State = 0,1,2,0,1,2,3 after those edges.
  - OP=1 during t=87–95.
  - C_State=0 after the edge at 95.
- Non-overlap: feed 1,0,1,0,1,0 on consecutive edges -> exactly one OP pulse, on the first "1010" only; the second "10" is not a match.
- Restart on 1011: sample 1,0,1,1,0,1 then In=0 -> states 1,2,3,1,2,3.
  - OP stays 0 until the final 0.
  - OP then pulses once, e.g. t=158–165, and C_State returns to 0.
- Mealy glitch/timing: in S3, toggle In 1->0->1 between edges -> OP follows In combinationally (high only while In=0). The state after the edge reflects only the value at the edge.
- Idle stability: long runs of 0s from S0 and of 1s from S1 -> state unchanged and OP=0.

Source files
------------

// File: rtl/mealy_1010_seq_det_non_over_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mealy_1010_seq_det_non_over_pkg
// Brief    : State type and encodings for the 1010 non-overlapping detector.
// Revision : 1.0 - initial release
// ============================================================================
package mealy_1010_seq_det_non_over_pkg;

  typedef logic [1:0] state_t;

  localparam state_t S0 = 2'b00;  // idle, no progress
  localparam state_t S1 = 2'b01;  // seen "1"
  localparam state_t S2 = 2'b10;  // seen "10"
  localparam state_t S3 = 2'b11;  // seen "101"

endpackage
`default_nettype wire

// File: rtl/mealy_1010_seq_det_non_over_if.sv
`default_nettype none
// ============================================================================
// Module   : mealy_1010_seq_det_non_over_if
// Brief    : Serial data / match-flag bundle for the 1010 detector.
// Revision : 1.0 - initial release
// ============================================================================
interface mealy_1010_seq_det_non_over_if;

  logic data;
  logic match;

  modport master (output data, input match);
  modport slave  (input data, output match);

endinterface
`default_nettype wire

// File: rtl/mealy_1010_seq_det_non_over.sv
`default_nettype none
// ============================================================================
// Module   : mealy_1010_seq_det_non_over
// Brief    : Mealy FSM detecting serial pattern 1010, non-overlapping mode.
// Revision : 1.0 - initial release
// ============================================================================
module mealy_1010_seq_det_non_over
  import mealy_1010_seq_det_non_over_pkg::*;
(
  input  logic Clk,
  input  logic Rst,
  input  logic In,
  output logic OP
);

  state_t C_State;
  state_t N_State;

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) C_State <= S0;
    else      C_State <= N_State;
  end

  // A completed match returns to idle so its bits are never reused.
  always_comb begin
    N_State = S0;
    OP      = 1'b0;
    case (C_State)
      S0: N_State = In ? S1 : S0;
      S1: N_State = In ? S1 : S2;
      S2: N_State = In ? S3 : S0;
      S3: begin
        if (In) begin
          N_State = S1;
        end else begin
          N_State = S0;
          OP      = Rst;
        end
      end
      default: N_State = S0;
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_mealy_1010_seq_det_non_over.sv
`default_nettype none
// ============================================================================
// Module   : tb_mealy_1010_seq_det_non_over
// Brief    : Scoreboard bench for the 1010 non-overlapping Mealy detector.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mealy_1010_seq_det_non_over;

  logic Clk;
  logic Rst;
  mealy_1010_seq_det_non_over_if bus ();

  mealy_1010_seq_det_non_over dut (
    .Clk (Clk),
    .Rst (Rst),
    .In  (bus.data),
    .OP  (bus.match)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  typedef struct {
    string       tag;
    logic        op;
    logic [1:0]  st;
  } sb_item_t;

  sb_item_t sb[$];
  int checks = 0;
  int errors = 0;
  int pulses = 0;

  // Reference: bits seen since the last restart; progress is the longest
  // suffix of that history that is also a prefix of 1010.
  logic [3:0] hist = 4'b0;
  int         hlen = 0;

  task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [1:0] model_progress();
    if (hlen >= 3 && hist[2:0] == 3'b101) return 2'd3;
    if (hlen >= 2 && hist[1:0] == 2'b10)  return 2'd2;
    if (hlen >= 1 && hist[0] == 1'b1)     return 2'd1;
    return 2'd0;
  endfunction

  function automatic void model_step(input logic b);
    if (model_progress() == 2'd3 && !b) begin
      hist = 4'b0;
      hlen = 0;
    end else begin
      hist = {hist[2:0], b};
      if (hlen < 4) hlen++;
    end
  endfunction

  function automatic void model_clear();
    hist = 4'b0;
    hlen = 0;
  endfunction

  task automatic drive_bit(input logic b, input string tag);
    sb_item_t it;
    @(negedge Clk);
    bus.data = b;
    it.tag = tag;
    it.st  = model_progress();
    it.op  = (it.st == 2'd3) && !b;
    sb.push_back(it);
    #4;
    if (sb.size() == 0) begin
      check_value({tag, "_sb_empty"}, 32'd1, 32'd0);
    end else begin
      it = sb.pop_front();
      check_value({it.tag, "_op"}, 32'(bus.match), 32'(it.op));
      check_value({it.tag, "_st"}, 32'(dut.C_State), 32'(it.st));
      if (bus.match === 1'b1) pulses++;
    end
    @(posedge Clk);
    model_step(b);
    #1;
    check_value({tag, "_next"}, 32'(dut.C_State), 32'(model_progress()));
  endtask

  task automatic drive_seq(input logic [15:0] bits, input int n, input string tag);
    for (int i = n - 1; i >= 0; i--) drive_bit(bits[i], $sformatf("%s%0d", tag, n - 1 - i));
  endtask

  initial begin
    Rst      = 1'b0;
    bus.data = 1'b0;
    #3;
    check_value("rst_st_a", 32'(dut.C_State), 32'd0);
    check_value("rst_op_a", 32'(bus.match), 32'd0);
    #9;
    check_value("rst_st_b", 32'(dut.C_State), 32'd0);
    check_value("rst_op_b", 32'(bus.match), 32'd0);
    #5 Rst = 1'b1;

    // Basic match: 0,1,0,0,1,0,1 then final 0.
    drive_seq(16'b0100101_0, 8, "basic");
    check_value("basic_pulses", 32'(pulses), 32'd1);

    // Non-overlap: 101010 gives a single pulse.
    pulses = 0;
    drive_seq(16'b101010, 6, "novl");
    check_value("novl_pulses", 32'(pulses), 32'd1);

    // Back to idle, then 1011 restart followed by 010.
    drive_bit(1'b0, "idle_pre");
    pulses = 0;
    drive_seq(16'b1011010, 7, "rst1011");
    check_value("r1011_pulses", 32'(pulses), 32'd1);

    // Asynchronous reset while sitting in S3 with In=0.
    drive_seq(16'b101, 3, "pre_rst");
    @(negedge Clk);
    bus.data = 1'b0;
    #1 check_value("s3_op_before_rst", 32'(bus.match), 32'd1);
    #1 Rst = 1'b0;
    #1;
    check_value("midrst_st", 32'(dut.C_State), 32'd0);
    check_value("midrst_op", 32'(bus.match), 32'd0);
    #1 Rst = 1'b1;
    model_clear();
    @(posedge Clk);
    #1 check_value("post_rst_st", 32'(dut.C_State), 32'd0);

    // Mealy glitch in S3: OP follows In between edges.
    drive_seq(16'b101, 3, "pre_gl");
    @(negedge Clk);
    bus.data = 1'b1;
    #1;
    check_value("gl_op_hi_in", 32'(bus.match), 32'd0);
    check_value("gl_ns_hi_in", 32'(dut.N_State), 32'd1);
    bus.data = 1'b0;
    #1;
    check_value("gl_op_lo_in", 32'(bus.match), 32'd1);
    check_value("gl_ns_lo_in", 32'(dut.N_State), 32'd0);
    bus.data = 1'b1;
    #1 check_value("gl_op_back", 32'(bus.match), 32'd0);
    @(posedge Clk);
    model_step(1'b1);
    #1 check_value("gl_edge_st", 32'(dut.C_State), 32'(model_progress()));

    // Idle stability: 1s hold S1, then 0s hold S0.
    pulses = 0;
    drive_seq(16'b111111, 6, "ones");
    drive_seq(16'b00000000, 8, "zeros");
    check_value("idle_pulses", 32'(pulses), 32'd0);

    check_value("sb_drain", 32'(sb.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
`default_nettype wire
